// File: rtl/stripes_pkg.sv
// Shared types and default sizes for the Stripes bit-serial datapath blocks.
package stripes_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_VEC_LENGTH   = 16;

  // The MAC's column index port is this wide; WEIGHT_WIDTH must not exceed 2**COL_W.
  localparam int COL_W = $clog2(DEF_WEIGHT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/stripes_bitserial_sequencer_bitplane_select.sv
// Combinational bit-plane extraction: lane j of the plane is bit col of weight j.
module bitplane_select
  import stripes_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int VEC_LENGTH   = DEF_VEC_LENGTH
) (
  input  logic [VEC_LENGTH-1:0][WEIGHT_WIDTH-1:0] w,
  input  logic [COL_W-1:0]                        col,
  output logic [VEC_LENGTH-1:0]                   plane
);

  always_comb begin
    plane = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      plane[j] = w[j][col];
    end
  end

endmodule

// File: rtl/stripes_bitserial_sequencer.sv
// Feeds one vector per handshake to the Stripes bit-serial MAC as LSB-first weight
// bit-planes, chains vectors into a dot-product group and flushes the MAC at group end.
module stripes_bitserial_sequencer
  import stripes_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int VEC_LENGTH   = DEF_VEC_LENGTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_in,
  input  logic [VEC_LENGTH-1:0][WEIGHT_WIDTH-1:0] w_in,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_out,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic [COL_W-1:0]                      column_idx,
  output logic                                  is_msb,
  output logic                                  mac_en,
  output logic                                  load_accum,
  output logic                                  out_valid,
  output logic                                  busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_WIDTH - 1);

  seq_state_t state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_q;
  logic [VEC_LENGTH-1:0][WEIGHT_WIDTH-1:0] w_q;
  logic last_q, first_q, ld_pend, load_accum_q, out_valid_q;
  logic at_last_col, accept;
  logic [VEC_LENGTH-1:0] plane;

  bitplane_select #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .VEC_LENGTH   (VEC_LENGTH)
  ) u_bitplane_select (
    .w     (w_q),
    .col   (col),
    .plane (plane)
  );

  assign at_last_col = (col == LAST_COL);
  // Ready is a pure function of state so the upstream can never form a loop through in_valid.
  assign in_ready    = (state == IDLE) || ((state == RUN) && at_last_col && !last_q);
  assign accept      = in_valid && in_ready;

  assign act_out    = act_q;
  assign load_accum = load_accum_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    mac_en     = 1'b0;
    column_idx = '0;
    is_msb     = 1'b0;
    w_bit      = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          col_nxt   = '0;
        end
      end
      RUN: begin
        mac_en     = 1'b1;
        column_idx = col;
        is_msb     = at_last_col;
        w_bit      = plane;
        col_nxt    = col + COL_W'(1);
        if (at_last_col) begin
          col_nxt = '0;
          if (accept)      state_nxt = RUN;
          else if (last_q) state_nxt = DRAIN;
          else             state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // Zero plane with en high pushes the last column in and clears the MAC shift stage.
        mac_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      // NOTE: the held operand registers are cleared too, so the MAC never sees stale data after reset.
      act_q        <= '0;
      w_q          <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b1;
      ld_pend      <= 1'b0;
      load_accum_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      // Column 0 reaches the MAC shift stage one cycle after it is presented; load then.
      ld_pend      <= accept && first_q;
      load_accum_q <= ld_pend;
      out_valid_q  <= (state == DRAIN);
      if (accept) begin
        act_q  <= act_in;
        w_q    <= w_in;
        last_q <= in_last;
        if (!in_last) first_q <= 1'b0;
      end
      if (state == DRAIN) first_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stripes_bitserial_sequencer.sv
// Self-checking bench: a per-cycle expected-output timeline plus a dot-product model,
// driven by directed cases and randomized multi-vector groups.
module tb_stripes_bitserial_sequencer;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int VL = 16;
  localparam int TL_DEPTH = 16384;

  logic clk, reset, in_valid, in_ready, in_last;
  logic [VL-1:0][DW-1:0] act_in, act_out;
  logic [VL-1:0][WW-1:0] w_in;
  logic [VL-1:0] w_bit;
  logic [2:0] column_idx;
  logic is_msb, mac_en, load_accum, out_valid, busy;

  stripes_bitserial_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .act_in     (act_in),
    .w_in       (w_in),
    .act_out    (act_out),
    .w_bit      (w_bit),
    .column_idx (column_idx),
    .is_msb     (is_msb),
    .mac_en     (mac_en),
    .load_accum (load_accum),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle.
  typedef struct {
    bit        ready;
    bit        busy;
    bit        en;
    bit [2:0]  col;
    bit        msb;
    bit        la;
    bit        ov;
    bit [15:0] wb;
  } exp_t;

  exp_t tl [TL_DEPTH];
  int unsigned cyc;
  int n_vec, n_chk, n_err;
  bit armed;

  // Model state
  logic [127:0] m_act;
  bit     m_first;
  longint m_dot;
  longint exp_res[$];
  int unsigned grp_start;

  // Observations of the DUT
  longint recon, last_res;
  int unsigned last_lat, la_off;
  int la_cnt, last_la, ov_total;
  bit got_accept, ov_seen;

  function automatic exp_t idle_rec();
    exp_t e;
    e = '{ready: 1'b1, busy: 1'b0, en: 1'b0, col: 3'd0, msb: 1'b0, la: 1'b0, ov: 1'b0, wb: 16'h0};
    return e;
  endfunction

  function automatic longint dot(input logic [127:0] a, input logic [127:0] w);
    longint s;
    s = 0;
    for (int j = 0; j < VL; j++)
      s += longint'($signed(a[j*8 +: 8])) * longint'($signed(w[j*8 +: 8]));
    return s;
  endfunction

  function automatic bit [15:0] plane_of(input logic [127:0] w, input int k);
    bit [15:0] p;
    for (int j = 0; j < VL; j++) p[j] = w[j*8 + k];
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Schedule the expected outputs of a vector accepted in cycle t.
  task automatic schedule(input int unsigned t, input logic [127:0] w, input bit last, input bit first);
    for (int k = 0; k < WW; k++) begin
      tl[t+1+k] = '{ready: (k == WW-1) && !last, busy: 1'b1, en: 1'b1, col: 3'(k),
                    msb: (k == WW-1), la: 1'b0, ov: 1'b0, wb: plane_of(w, k)};
    end
    if (first) tl[t+2].la = 1'b1;
    if (last) begin
      tl[t+WW+1] = '{ready: 1'b0, busy: 1'b1, en: 1'b1, col: 3'd0, msb: 1'b0,
                     la: 1'b0, ov: 1'b0, wb: 16'h0};
      tl[t+WW+2].ov = 1'b1;
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic compare_cycle();
    exp_t e;
    longint s;
    e = tl[cyc];
    if (armed) begin
      check("in_ready",   in_ready,   e.ready);
      check("busy",       busy,       e.busy);
      check("mac_en",     mac_en,     e.en);
      check("column_idx", column_idx, e.col);
      check("is_msb",     is_msb,     e.msb);
      check("load_accum", load_accum, e.la);
      check("out_valid",  out_valid,  e.ov);
      check("w_bit",      w_bit,      e.wb);
      check("act_out",    act_out,    m_act);
      if (out_valid) begin
        ov_total++;
        ov_seen  = 1'b1;
        last_res = recon;
        last_lat = cyc - grp_start;
        last_la  = la_cnt;
        if (exp_res.size() > 0) check_int("group_result", recon, exp_res.pop_front());
        recon  = 0;
        la_cnt = 0;
      end
      if (load_accum) begin
        la_cnt++;
        la_off = cyc - grp_start;
      end
      if (mac_en) begin
        s = 0;
        for (int j = 0; j < VL; j++)
          if (w_bit[j]) s += longint'($signed(act_out[j]));
        s = s * (longint'(1) << column_idx);
        recon += is_msb ? -s : s;
      end
    end
    if (reset) begin
      for (int i = 1; i <= 14; i++) tl[cyc+i] = idle_rec();
      m_act   = '0;
      m_first = 1'b1;
      m_dot   = 0;
      exp_res.delete();
      recon   = 0;
      la_cnt  = 0;
    end else if (in_valid && e.ready) begin
      got_accept = 1'b1;
      n_vec++;
      if (m_first) grp_start = cyc;
      schedule(cyc, w_in, in_last, m_first);
      m_act  = act_in;
      m_dot += dot(act_in, w_in);
      if (in_last) begin
        exp_res.push_back(m_dot);
        m_dot   = 0;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_vec(input logic [127:0] a, input logic [127:0] w, input bit last);
    act_in = a; w_in = w; in_last = last; in_valid = 1'b1;
    got_accept = 1'b0;
    for (int i = 0; i < 40 && !got_accept; i++) tick();
    check("vector_accepted", got_accept, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int budget);
    ov_seen = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < budget && !ov_seen; i++) tick();
    check("out_valid_seen", ov_seen, 1'b1);
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] r;
    for (int j = 0; j < VL; j++) r[j*8 +: 8] = v;
    return r;
  endfunction

  initial begin
    logic [127:0] a, w;
    int ov_before, len;
    for (int i = 0; i < TL_DEPTH; i++) tl[i] = idle_rec();
    cyc = 0; n_vec = 0; n_chk = 0; n_err = 0; armed = 1'b0;
    m_act = '0; m_first = 1'b1; m_dot = 0; recon = 0; la_cnt = 0; ov_total = 0;
    grp_start = 0; last_res = 0; last_lat = 0; last_la = 0; la_off = 0;
    in_valid = 1'b0; in_last = 1'b0; act_in = '0; w_in = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    armed = 1'b1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_act_out", act_out, 128'h0);

    // Single vector, acts 1, weights -1.
    send_vec(fill(8'h01), fill(8'hFF), 1'b1);
    wait_ov(30);
    check_int("t1_result", last_res, -16);
    check_int("t1_latency", last_lat, 10);
    check_int("t1_load_accum_count", last_la, 1);
    check_int("t1_load_accum_offset", la_off, 2);
    idle(2);

    // Two vectors back-to-back.
    send_vec(fill(8'h02), fill(8'h03), 1'b0);
    send_vec(fill(8'h02), fill(8'hFB), 1'b1);
    wait_ov(40);
    check_int("t2_result", last_res, -64);
    check_int("t2_latency", last_lat, 18);
    check_int("t2_load_accum_count", last_la, 1);
    idle(2);

    // Same two vectors with a 3-cycle stall between them.
    send_vec(fill(8'h02), fill(8'h03), 1'b0);
    idle(10);
    send_vec(fill(8'h02), fill(8'hFB), 1'b1);
    wait_ov(40);
    check_int("t3_result", last_res, -64);
    check_int("t3_latency", last_lat, 21);

    // Two consecutive single-vector groups.
    for (int g = 0; g < 2; g++) begin
      send_vec(fill(8'h01), fill(8'h01), 1'b1);
      wait_ov(30);
      check_int("t4_result", last_res, 16);
      check_int("t4_load_accum_count", last_la, 1);
    end

    // MSB-only weight in lane 0.
    w = '0;
    w[7:0] = 8'h80;
    send_vec(fill(8'h01), w, 1'b1);
    wait_ov(30);
    check_int("t5_result", last_res, -128);

    // Reset in column 4, then a clean group.
    send_vec(fill(8'h05), fill(8'h07), 1'b1);
    idle(4);
    check("t6_col_before_reset", column_idx, 3'd4);
    ov_before = ov_total;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_mac_en", mac_en, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    idle(12);
    check_int("t6_no_out_valid", ov_total, ov_before);
    send_vec(fill(8'h03), fill(8'hFE), 1'b1);
    wait_ov(30);
    check_int("t6_result_after_reset", last_res, -96);

    // Randomized groups with random gaps.
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 3);
      for (int v = 0; v < len; v++) begin
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_vec(a, w, v == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    wait_ov(40);
    idle(3);
    check_int("pending_results", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
